ilv_bit_interleaver: RTL and testbench

ILV_BIT_INTERLEAVER -- requirements
Module: ilv_bit_interleaver

---
 rtl/ilv_bit_interleaver.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ilv_bit_interleaver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ilv_bit_interleaver.sv
// Ping-pong block bit interleaver between the puncturer and the QAM mapper.
// Build option: define ILV_SECOND_PERM_EN to enable the second (s-based) permutation; otherwise j = i.
module ilv_bit_interleaver #(
    parameter int BANK_DEPTH = 288
) (
    input  logic       cb_clk,
    input  logic       rst_n,
    input  logic       tx_clr,
    input  logic [1:0] map_type,
    input  logic       ilv_din,
    input  logic       ilv_en,
    output logic       ilv_dout,
    output logic       ilv_vld,
    output logic [1:0] ilv_map_type,
    output logic       ilv_last,
    output logic       ilv_ovf
);

    typedef enum logic [1:0] {
        BANK_FREE    = 2'b00,
        BANK_FULL    = 2'b01,
        BANK_READING = 2'b10
    } bank_state_t;

    // NCBPS/16: number of rows in the 16-column write matrix.
    function automatic logic [4:0] rows_of(input logic [1:0] mt);
        logic [4:0] r;
        case (mt)
            2'b00:   r = 5'd3;
            2'b01:   r = 5'd6;
            2'b10:   r = 5'd12;
            default: r = 5'd18;
        endcase
        return r;
    endfunction

    function automatic logic [8:0] ncbps_of(input logic [1:0] mt);
        logic [8:0] n;
        case (mt)
            2'b00:   n = 9'd48;
            2'b01:   n = 9'd96;
            2'b10:   n = 9'd192;
            default: n = 9'd288;
        endcase
        return n;
    endfunction

`ifdef ILV_SECOND_PERM_EN
    // (a - b) mod 3 for residues a, b in 0..2.
    function automatic logic [1:0] mod3_sub(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        case ({a, b})
            4'b0000, 4'b0101, 4'b1010: d = 2'd0;
            4'b0100, 4'b1001, 4'b0010: d = 2'd1;
            4'b1000, 4'b0001, 4'b0110: d = 2'd2;
            default:                   d = 2'd0;
        endcase
        return d;
    endfunction
`endif

    bank_state_t          bank_st_r [2];
    bank_state_t          bank_st_s [2];
    logic [1:0]           bank_map_r [2];
    logic [BANK_DEPTH-1:0] bank_mem_r [2];

    logic       wr_bank_r;
    logic [1:0] wr_map_r;
    logic [3:0] col_r;
    logic [4:0] row_r;
    logic [8:0] i_r;
`ifdef ILV_SECOND_PERM_EN
    logic [1:0] row_mod3_r;
    logic [1:0] col_mod3_r;
`endif

    logic       rd_busy_r;
    logic       rd_bank_r;
    logic [8:0] rd_addr_r;

    logic       k_zero_s;
    logic [1:0] eff_map_s;
    logic [4:0] rows_s;
    logic       wr_avail_s;
    logic       accept_s;
    logic       drop_s;
    logic       wr_last_s;
    logic [8:0] wr_addr_s;
    logic       rd_start_s;
    logic       issue_s;
    logic [8:0] rd_cur_addr_s;
    logic       rd_final_s;
    logic       rd_bit_s;

    // At k = 0 the incoming map_type applies; afterwards the latched one does.
    assign k_zero_s   = (col_r == 4'd0) && (row_r == 5'd0);
    assign eff_map_s  = k_zero_s ? map_type : wr_map_r;
    assign rows_s     = rows_of(eff_map_s);
    assign wr_avail_s = (bank_st_r[wr_bank_r] == BANK_FREE);
    assign accept_s   = ilv_en && wr_avail_s && !tx_clr;
    assign drop_s     = ilv_en && !wr_avail_s && !tx_clr;
    assign wr_last_s  = (col_r == 4'd15) && (row_r == (rows_s - 5'd1));

    // Write address: i = rows*col + row; floor(16*i/NCBPS) equals col, so no divider is needed.
    always_comb begin
        wr_addr_s = i_r;
`ifdef ILV_SECOND_PERM_EN
        case (eff_map_s)
            2'b10:   wr_addr_s = {i_r[8:1], i_r[0] ^ col_r[0]};
            2'b11:   wr_addr_s = i_r - {7'd0, row_mod3_r} + {7'd0, mod3_sub(row_mod3_r, col_mod3_r)};
            default: wr_addr_s = i_r;
        endcase
`endif
    end

    // Write-side index counters, bank pointer and map_type latch.
    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r <= 1'b0;
            wr_map_r  <= 2'b00;
            col_r     <= 4'd0;
            row_r     <= 5'd0;
            i_r       <= 9'd0;
        end else if (tx_clr) begin
            wr_bank_r <= 1'b0;
            wr_map_r  <= 2'b00;
            col_r     <= 4'd0;
            row_r     <= 5'd0;
            i_r       <= 9'd0;
        end else if (accept_s) begin
            if (k_zero_s) begin
                wr_map_r <= map_type;
            end
            if (wr_last_s) begin
                wr_bank_r <= ~wr_bank_r;
                col_r     <= 4'd0;
                row_r     <= 5'd0;
                i_r       <= 9'd0;
            end else if (col_r == 4'd15) begin
                col_r <= 4'd0;
                row_r <= row_r + 5'd1;
                i_r   <= {4'd0, row_r} + 9'd1;
            end else begin
                col_r <= col_r + 4'd1;
                i_r   <= i_r + {4'd0, rows_s};
            end
        end
    end

`ifdef ILV_SECOND_PERM_EN
    // Residues mod 3 of row and col; rows is a multiple of 3 for 64-QAM so i mod 3 == row mod 3.
    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_mod3_r <= 2'd0;
            col_mod3_r <= 2'd0;
        end else if (tx_clr) begin
            row_mod3_r <= 2'd0;
            col_mod3_r <= 2'd0;
        end else if (accept_s) begin
            if (wr_last_s) begin
                row_mod3_r <= 2'd0;
                col_mod3_r <= 2'd0;
            end else if (col_r == 4'd15) begin
                col_mod3_r <= 2'd0;
                row_mod3_r <= (row_mod3_r == 2'd2) ? 2'd0 : row_mod3_r + 2'd1;
            end else begin
                col_mod3_r <= (col_mod3_r == 2'd2) ? 2'd0 : col_mod3_r + 2'd1;
            end
        end
    end
`endif

    // Bank storage; contents need no reset.
    always_ff @(posedge cb_clk) begin
        if (accept_s) begin
            bank_mem_r[wr_bank_r][wr_addr_s] <= ilv_din;
        end
    end

    // Read engine start: a FULL bank begins as soon as no read is in progress.
    always_comb begin
        rd_start_s    = 1'b0;
        rd_cur_addr_s = 9'd0;
        if (rd_busy_r) begin
            rd_cur_addr_s = rd_addr_r;
        end else if (bank_st_r[rd_bank_r] == BANK_FULL) begin
            rd_start_s = 1'b1;
        end else begin
            rd_start_s = 1'b0;
        end
    end

    assign issue_s    = rd_busy_r || rd_start_s;
    assign rd_final_s = issue_s && (rd_cur_addr_s == (ncbps_of(bank_map_r[rd_bank_r]) - 9'd1));
    assign rd_bit_s   = bank_mem_r[rd_bank_r][rd_cur_addr_s];

    // Per-bank next state; fill, start and drain events never coincide on one bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_s[b] = bank_st_r[b];
            if (accept_s && wr_last_s && (wr_bank_r == 1'(b))) begin
                bank_st_s[b] = BANK_FULL;
            end else if (rd_start_s && (rd_bank_r == 1'(b))) begin
                bank_st_s[b] = BANK_READING;
            end else if (rd_final_s && (rd_bank_r == 1'(b))) begin
                bank_st_s[b] = BANK_FREE;
            end else begin
                bank_st_s[b] = bank_st_r[b];
            end
        end
    end

    // Bank state and per-bank modulation registers.
    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_r[0]  <= BANK_FREE;
            bank_st_r[1]  <= BANK_FREE;
            bank_map_r[0] <= 2'b00;
            bank_map_r[1] <= 2'b00;
        end else if (tx_clr) begin
            bank_st_r[0]  <= BANK_FREE;
            bank_st_r[1]  <= BANK_FREE;
            bank_map_r[0] <= 2'b00;
            bank_map_r[1] <= 2'b00;
        end else begin
            bank_st_r <= bank_st_s;
            if (accept_s && wr_last_s) begin
                bank_map_r[wr_bank_r] <= wr_map_r;
            end
        end
    end

    // Read address counter; banks are drained in the same alternating order they are filled.
    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy_r <= 1'b0;
            rd_bank_r <= 1'b0;
            rd_addr_r <= 9'd0;
        end else if (tx_clr) begin
            rd_busy_r <= 1'b0;
            rd_bank_r <= 1'b0;
            rd_addr_r <= 9'd0;
        end else if (issue_s) begin
            if (rd_final_s) begin
                rd_busy_r <= 1'b0;
                rd_bank_r <= ~rd_bank_r;
                rd_addr_r <= 9'd0;
            end else begin
                rd_busy_r <= 1'b1;
                rd_addr_r <= rd_cur_addr_s + 9'd1;
            end
        end
    end

    // Registered outputs toward the mapper.
    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            ilv_dout     <= 1'b0;
            ilv_vld      <= 1'b0;
            ilv_last     <= 1'b0;
            ilv_ovf      <= 1'b0;
            ilv_map_type <= 2'b00;
        end else if (tx_clr) begin
            ilv_dout     <= 1'b0;
            ilv_vld      <= 1'b0;
            ilv_last     <= 1'b0;
            ilv_ovf      <= 1'b0;
            ilv_map_type <= 2'b00;
        end else begin
            ilv_dout <= issue_s && rd_bit_s;
            ilv_vld  <= issue_s;
            ilv_last <= rd_final_s;
            ilv_ovf  <= drop_s;
            if (issue_s) begin
                ilv_map_type <= bank_map_r[rd_bank_r];
            end
        end
    end

endmodule

// File: tb/tb_ilv_bit_interleaver.sv
// Directed, table-driven bench for ilv_bit_interleaver (expected indices follow ILV_SECOND_PERM_EN).
module tb_ilv_bit_interleaver;

    logic       cb_clk = 1'b0;
    logic       rst_n;
    logic       tx_clr;
    logic [1:0] map_type;
    logic       ilv_din;
    logic       ilv_en;
    logic       ilv_dout;
    logic       ilv_vld;
    logic [1:0] ilv_map_type;
    logic       ilv_last;
    logic       ilv_ovf;

    ilv_bit_interleaver dut (
        .cb_clk       (cb_clk),
        .rst_n        (rst_n),
        .tx_clr       (tx_clr),
        .map_type     (map_type),
        .ilv_din      (ilv_din),
        .ilv_en       (ilv_en),
        .ilv_dout     (ilv_dout),
        .ilv_vld      (ilv_vld),
        .ilv_map_type (ilv_map_type),
        .ilv_last     (ilv_last),
        .ilv_ovf      (ilv_ovf)
    );

    always #5 cb_clk = ~cb_clk;

`ifdef ILV_SECOND_PERM_EN
    localparam bit PERM_EN = 1'b1;
`else
    localparam bit PERM_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0] mt;
        int         n;
        int         one_k;
        int         exp_idx;
    } vec_t;

    vec_t vecs [11];

    int n_tests = 0;
    int n_fail  = 0;

    // output monitor state
    int cyc = 0;
    int vld_cnt, ones_cnt, one_idx, last_cnt, last_idx, first_vld_cyc;
    int gap_cnt, map_err, ovf_cnt, idle_err, exp_map_mon;
    int last_pos [4];
    bit prev_vld;

    always @(posedge cb_clk) begin
        #1;
        cyc++;
        if (ilv_vld) begin
            if (vld_cnt == 0) first_vld_cyc = cyc;
            else if (!prev_vld) gap_cnt++;
            if (ilv_dout) begin
                ones_cnt++;
                one_idx = vld_cnt;
            end
            if (ilv_last) begin
                if (last_cnt < 4) last_pos[last_cnt] = vld_cnt;
                last_cnt++;
                last_idx = vld_cnt;
            end
            if (exp_map_mon >= 0 && int'(ilv_map_type) != exp_map_mon) map_err++;
            vld_cnt++;
        end else if (ilv_dout || ilv_last) begin
            idle_err++;
        end
        if (ilv_ovf) ovf_cnt++;
        prev_vld = ilv_vld;
    end

    task automatic mon_clear(input int exp_map);
        vld_cnt = 0; ones_cnt = 0; one_idx = -1; last_cnt = 0; last_idx = -1;
        first_vld_cyc = -1; gap_cnt = 0; map_err = 0; ovf_cnt = 0; idle_err = 0;
        exp_map_mon = exp_map; prev_vld = 1'b0;
        for (int i = 0; i < 4; i++) last_pos[i] = -1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic d, input logic [1:0] mt, input logic clr);
        @(negedge cb_clk);
        ilv_en = en; ilv_din = d; map_type = mt; tx_clr = clr;
    endtask

    // One symbol at 1 bit/cycle; map_type switches to mt_late from k = switch_k on.
    task automatic send_symbol(input logic [1:0] mt, input logic [1:0] mt_late, input int switch_k,
                               input int n, input int one_k, output int acc);
        acc = -1;
        for (int k = 0; k < n; k++) begin
            drive(1'b1, (k == one_k), (k < switch_k) ? mt : mt_late, 1'b0);
            if (k == n - 1) acc = cyc;
        end
    endtask

    task automatic wait_lasts(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (last_cnt >= n) break;
            drive(1'b0, 1'b0, map_type, 1'b0);
        end
        repeat (3) drive(1'b0, 1'b0, map_type, 1'b0);
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int acc;
        mon_clear(int'(v.mt));
        send_symbol(v.mt, v.mt, v.n, v.n, v.one_k, acc);
        wait_lasts(1, v.n + 16);
        chk({tag, ".vld_count"},  vld_cnt, v.n);
        chk({tag, ".ones"},       ones_cnt, (v.one_k >= 0) ? 1 : 0);
        chk({tag, ".one_index"},  one_idx, v.exp_idx);
        chk({tag, ".last_count"}, last_cnt, 1);
        chk({tag, ".last_index"}, last_idx, v.n - 1);
        chk({tag, ".latency"},    first_vld_cyc - acc, 2);
        chk({tag, ".gaps"},       gap_cnt, 0);
        chk({tag, ".map_type"},   map_err, 0);
        chk({tag, ".ovf"},        ovf_cnt, 0);
        chk({tag, ".idle_dout"},  idle_err, 0);
    endtask

    initial begin
        int  acc;
        bit  clr_hit;

        vecs[0]  = '{2'b00,  48,   1, 3};
        vecs[1]  = '{2'b10, 192,   1, PERM_EN ? 13 : 12};
        vecs[2]  = '{2'b11, 288,  17, PERM_EN ? 18 : 19};
        vecs[3]  = '{2'b11, 288,   0, 0};
        vecs[4]  = '{2'b01,  96,   1, 6};
        vecs[5]  = '{2'b00,  48,  47, 47};
        vecs[6]  = '{2'b10, 192, 191, PERM_EN ? 190 : 191};
        vecs[7]  = '{2'b11, 288, 287, 287};
        vecs[8]  = '{2'b11, 288,   2, PERM_EN ? 37 : 36};
        vecs[9]  = '{2'b10, 192,   3, PERM_EN ? 37 : 36};
        vecs[10] = '{2'b01,  96,  -1, -1};

        rst_n = 1'b0; tx_clr = 1'b0; ilv_en = 1'b0; ilv_din = 1'b0; map_type = 2'b00;
        mon_clear(-1);
        repeat (3) @(negedge cb_clk);
        chk("rst.dout", int'(ilv_dout), 0);
        chk("rst.vld",  int'(ilv_vld), 0);
        chk("rst.last", int'(ilv_last), 0);
        chk("rst.ovf",  int'(ilv_ovf), 0);
        chk("rst.map",  int'(ilv_map_type), 0);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 2'b00, 1'b0);

        for (int v = 0; v < 11; v++) begin
            run_vector(vecs[v], $sformatf("vec%0d", v));
        end

        // three back-to-back QPSK symbols
        mon_clear(1);
        send_symbol(2'b01, 2'b01, 96, 96, 1, acc);
        begin
            int a2, a3;
            send_symbol(2'b01, 2'b01, 96, 96, 1, a2);
            send_symbol(2'b01, 2'b01, 96, 96, 1, a3);
        end
        wait_lasts(3, 400);
        chk("qpsk3.vld_count", vld_cnt, 288);
        chk("qpsk3.gaps",      gap_cnt, 0);
        chk("qpsk3.lasts",     last_cnt, 3);
        chk("qpsk3.last0",     last_pos[0], 95);
        chk("qpsk3.last1",     last_pos[1], 191);
        chk("qpsk3.last2",     last_pos[2], 287);
        chk("qpsk3.ones",      ones_cnt, 3);
        chk("qpsk3.latency",   first_vld_cyc - acc, 2);
        chk("qpsk3.ovf",       ovf_cnt, 0);
        chk("qpsk3.map_type",  map_err, 0);

        // map_type change mid-symbol is ignored; next symbol takes the new type
        mon_clear(2);
        send_symbol(2'b10, 2'b00, 100, 192, 1, acc);
        wait_lasts(1, 220);
        chk("maptog.vld_count", vld_cnt, 192);
        chk("maptog.one_index", one_idx, PERM_EN ? 13 : 12);
        chk("maptog.map_type",  map_err, 0);
        chk("maptog.last_index", last_idx, 191);
        run_vector(vecs[0], "maptog_next");

        // overflow: long symbol reading while a short one fills the other bank
        mon_clear(-1);
        send_symbol(2'b11, 2'b11, 288, 288, -1, acc);
        send_symbol(2'b00, 2'b00, 48, 48, 1, acc);
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        wait_lasts(2, 800);
        chk("ovf.pulses",    ovf_cnt, 1);
        chk("ovf.vld_count", vld_cnt, 336);
        chk("ovf.gaps",      gap_cnt, 0);
        chk("ovf.one_index", one_idx, 291);
        chk("ovf.ones",      ones_cnt, 1);
        run_vector(vecs[0], "ovf_next");

        // tx_clr at output index 20, with ilv_en asserted in the same cycle
        mon_clear(0);
        send_symbol(2'b00, 2'b00, 48, 48, 25, acc);
        clr_hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge cb_clk);
            if (vld_cnt == 21) begin
                ilv_en = 1'b1; ilv_din = 1'b1; tx_clr = 1'b1;
                clr_hit = 1'b1;
                break;
            end
            ilv_en = 1'b0; ilv_din = 1'b0; tx_clr = 1'b0;
        end
        repeat (6) drive(1'b0, 1'b0, 2'b00, 1'b0);
        chk("clr.reached",   int'(clr_hit), 1);
        chk("clr.vld_count", vld_cnt, 21);
        chk("clr.lasts",     last_cnt, 0);
        chk("clr.ones",      ones_cnt, 0);
        chk("clr.idle_dout", idle_err, 0);
        run_vector(vecs[0], "clr_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
